// File: rtl/pc_src_select_reg.sv
// Registered next-PC source selector: loads pc from one of NUM_SRC slots each cycle,
// with stall hold, flush redirect, illegal-select logging and a post-reset valid flag.
module pc_src_select_reg #(
    parameter int              WIDTH     = 32,
    parameter int              NUM_SRC   = 8,
    parameter int              SEL_W     = 3,
    parameter int              SEQ_IDX   = 2,
    parameter int              INC       = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = 32'h0040_0000,
    parameter int              CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         flush_addr,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         pc_seq,
    output logic                     pc_valid,
    output logic [SEL_W-1:0]         last_sel,
    output logic                     sel_err,
    output logic [CNT_W-1:0]         err_cnt
);

    if (NUM_SRC < 2 || SEQ_IDX >= NUM_SRC || (1 << SEL_W) < NUM_SRC || CNT_W < 1) begin : g_param_check
        $error("pc_src_select_reg: illegal parameter combination");
    end

    localparam logic [SEL_W:0] NUM_SRC_EXT = (SEL_W+1)'(NUM_SRC);

    logic             sel_illegal;
    logic [WIDTH-1:0] src_pick;

    assign pc_seq      = pc + WIDTH'(INC);
    assign sel_illegal = ({1'b0, sel} >= NUM_SRC_EXT);

    // Every slot is read, then the sequential slot is overridden with pc + INC.
    always_comb begin
        src_pick = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) src_pick = src_flat[k*WIDTH +: WIDTH];
        end
        if (sel == SEL_W'(SEQ_IDX)) src_pick = pc_seq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VAL;
            pc_valid <= 1'b0;
            last_sel <= '0;
            sel_err  <= 1'b0;
            err_cnt  <= '0;
        end else if (flush) begin
            pc       <= flush_addr;
            pc_valid <= 1'b1;
        end else if (stall) begin
            pc       <= pc;
        end else if (sel_illegal) begin
            sel_err <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end else begin
            pc       <= src_pick;
            last_sel <= sel;
            pc_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_src_select_reg.sv
// Directed, table-driven bench for pc_src_select_reg (NUM_SRC = 5 so selects 5..7 are illegal).
module tb_pc_src_select_reg;

    localparam int W = 32;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst, stall, flush;
    logic [2:0]     sel;
    logic [N*W-1:0] src_flat;
    logic [W-1:0]   flush_addr;
    logic [W-1:0]   pc, pc_seq;
    logic           pc_valid;
    logic [2:0]     last_sel;
    logic           sel_err;
    logic [7:0]     err_cnt;

    logic [W-1:0] s0, s3;
    assign src_flat = {32'h4444_4444, s3, 32'hDEAD_BEEF, 32'h1111_1111, s0};

    pc_src_select_reg #(
        .WIDTH(W), .NUM_SRC(N), .SEL_W(3), .SEQ_IDX(2), .INC(4),
        .RESET_VAL(32'h0040_0000), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .src_flat(src_flat), .stall(stall),
        .flush(flush), .flush_addr(flush_addr), .pc(pc), .pc_seq(pc_seq),
        .pc_valid(pc_valid), .last_sel(last_sel), .sel_err(sel_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, stall, flush;
        logic [2:0]  sel;
        logic [31:0] s0, s3, fa;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [2:0]  e_last;
        logic        e_err;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vt[15];

    initial begin
        //          rst  stl  fls  sel   s0            s3            fa            e_pc          v     last  err   cnt
        vt[0]  = '{1'b1,1'b0,1'b0,3'd0,32'h0,        32'h0,        32'h0,        32'h0040_0000,1'b0,3'd0,1'b0,8'd0};
        vt[1]  = '{1'b0,1'b0,1'b0,3'd2,32'h0,        32'h0,        32'h0,        32'h0040_0004,1'b1,3'd2,1'b0,8'd0};
        vt[2]  = '{1'b0,1'b0,1'b0,3'd2,32'h0,        32'h0,        32'h0,        32'h0040_0008,1'b1,3'd2,1'b0,8'd0};
        vt[3]  = '{1'b0,1'b0,1'b0,3'd2,32'h0,        32'h0,        32'h0,        32'h0040_000C,1'b1,3'd2,1'b0,8'd0};
        vt[4]  = '{1'b0,1'b0,1'b0,3'd0,32'h0000_1000,32'h0,        32'h0,        32'h0000_1000,1'b1,3'd0,1'b0,8'd0};
        vt[5]  = '{1'b0,1'b0,1'b0,3'd3,32'h0000_1000,32'h0000_2000,32'h0,        32'h0000_2000,1'b1,3'd3,1'b0,8'd0};
        vt[6]  = '{1'b0,1'b0,1'b0,3'd0,32'h0000_1000,32'h0000_2000,32'h0,        32'h0000_1000,1'b1,3'd0,1'b0,8'd0};
        vt[7]  = '{1'b0,1'b1,1'b0,3'd0,32'h0000_5000,32'h0000_2000,32'h0,        32'h0000_1000,1'b1,3'd0,1'b0,8'd0};
        vt[8]  = '{1'b0,1'b1,1'b0,3'd3,32'h0000_5000,32'h0000_2000,32'h0,        32'h0000_1000,1'b1,3'd0,1'b0,8'd0};
        vt[9]  = '{1'b0,1'b0,1'b0,3'd0,32'h0000_5000,32'h0000_2000,32'h0,        32'h0000_5000,1'b1,3'd0,1'b0,8'd0};
        vt[10] = '{1'b0,1'b1,1'b1,3'd5,32'h0000_5000,32'h0000_2000,32'h0040_0004,32'h0040_0004,1'b1,3'd0,1'b0,8'd0};
        vt[11] = '{1'b0,1'b1,1'b0,3'd6,32'h0000_5000,32'h0000_2000,32'h0,        32'h0040_0004,1'b1,3'd0,1'b0,8'd0};
        vt[12] = '{1'b0,1'b0,1'b0,3'd4,32'h0000_5000,32'h0000_2000,32'h0,        32'h4444_4444,1'b1,3'd4,1'b0,8'd0};
        vt[13] = '{1'b1,1'b0,1'b1,3'd4,32'h0000_5000,32'h0000_2000,32'h0000_0123,32'h0040_0000,1'b0,3'd0,1'b0,8'd0};
        vt[14] = '{1'b0,1'b0,1'b1,3'd7,32'h0000_5000,32'h0000_2000,32'h0000_0123,32'h0000_0123,1'b1,3'd0,1'b0,8'd0};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; sel = '0; s0 = '0; s3 = '0; flush_addr = '0;

        for (int i = 0; i < 15; i++) begin
            rst = vt[i].rst; stall = vt[i].stall; flush = vt[i].flush; sel = vt[i].sel;
            s0 = vt[i].s0; s3 = vt[i].s3; flush_addr = vt[i].fa;
            tick();
            check($sformatf("v%0d_pc", i),       pc,                vt[i].e_pc);
            check($sformatf("v%0d_pc_seq", i),   pc_seq,            vt[i].e_pc + 32'd4);
            check($sformatf("v%0d_valid", i),    32'(pc_valid),     32'(vt[i].e_valid));
            check($sformatf("v%0d_last_sel", i), 32'(last_sel),     32'(vt[i].e_last));
            check($sformatf("v%0d_sel_err", i),  32'(sel_err),      32'(vt[i].e_err));
            check($sformatf("v%0d_err_cnt", i),  32'(err_cnt),      32'(vt[i].e_cnt));
        end

        // Illegal select after reset: pc holds, valid stays low, counter saturates.
        rst = 1'b1; flush = 1'b0; stall = 1'b0; sel = 3'd0;
        tick();
        rst = 1'b0; sel = 3'd6;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (c == 1) begin
                check("ill_first_pc",    pc,             32'h0040_0000);
                check("ill_first_valid", 32'(pc_valid),  32'd0);
                check("ill_first_err",   32'(sel_err),   32'd1);
                check("ill_first_cnt",   32'(err_cnt),   32'd1);
            end
            if (c == 254) check("ill_cnt_254", 32'(err_cnt), 32'd254);
            if (c == 255) check("ill_cnt_255", 32'(err_cnt), 32'd255);
        end
        check("ill_sat_cnt",  32'(err_cnt),  32'd255);
        check("ill_sat_err",  32'(sel_err),  32'd1);
        check("ill_sat_pc",   pc,            32'h0040_0000);
        check("ill_last_sel", 32'(last_sel), 32'd0);

        // A legal load does not clear the sticky error state.
        sel = 3'd0; s0 = 32'h0000_0ABC;
        tick();
        check("ill_legal_pc",  pc,            32'h0000_0ABC);
        check("ill_keep_err",  32'(sel_err),  32'd1);
        check("ill_keep_cnt",  32'(err_cnt),  32'd255);

        rst = 1'b1;
        tick();
        rst = 1'b0; sel = 3'd0;
        check("clr_pc",  pc,            32'h0040_0000);
        check("clr_err", 32'(sel_err),  32'd0);
        check("clr_cnt", 32'(err_cnt),  32'd0);

        // Sequential wrap at the top of the address space.
        flush = 1'b1; flush_addr = 32'hFFFF_FFFC;
        tick();
        check("wrap_pre_pc",  pc,     32'hFFFF_FFFC);
        check("wrap_pre_seq", pc_seq, 32'h0000_0000);
        flush = 1'b0; sel = 3'd2;
        tick();
        check("wrap_pc",  pc,     32'h0000_0000);
        check("wrap_seq", pc_seq, 32'h0000_0004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_src_select_reg.md
Name: pc_src_select_reg

Overview:
- Parametrised, registered successor to the CPU's combinational next-PC source selector.
- Holds the program counter and loads it each cycle from one of NUM_SRC sources chosen by `sel`.
- Sequential slot SEQ_IDX is generated internally as pc + INC.
- Adds stall hold, flush override with a vector address, illegal-select detection (sticky flag plus saturating counter) and a post-reset valid indication.
- Sits between the control unit / ALU / branch logic and instruction memory.

Parameters:
- WIDTH, 32, PC and source data width.
- NUM_SRC, 8, number of selectable source slots.
- SEL_W, 3, select width; must satisfy 2^SEL_W >= NUM_SRC.
- SEQ_IDX, 2, slot replaced internally by pc + INC; its `src_flat` field is ignored.
- INC, 4, sequential increment in bytes.
- RESET_VAL, 32'h0040_0000, PC value while `rst` is asserted.
- CNT_W, 8, width of the illegal-select counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- sel  in  SEL_W  source index for the next PC.
- src_flat  in  NUM_SRC*WIDTH  packed sources; slot k occupies bits [k*WIDTH +: WIDTH].
- stall  in  1  hold PC this cycle.
- flush  in  1  force PC to flush_addr this cycle.
- flush_addr  in  WIDTH  exception/redirect target.
- pc  out  WIDTH  current program counter (registered).
- pc_seq  out  WIDTH  combinational pc + INC, modulo 2^WIDTH.
- pc_valid  out  1  PC has been updated at least once since reset.
- last_sel  out  SEL_W  select used for the most recent load (registered).
- sel_err  out  1  sticky: an illegal select was taken.
- err_cnt  out  CNT_W  saturating count of illegal-select cycles.

Behaviour:
- Reset and clocking
  - One clock; reset is synchronous and active-high, sampled on the rising edge of `clk`.
  - While `rst` = 1 at an edge: pc = RESET_VAL, pc_valid = 0, last_sel = 0, sel_err = 0, err_cnt = 0.
  - `pc_seq` follows `pc`, so it equals RESET_VAL + INC.
  - Reset mid-operation overrides all other inputs on that edge.
- Per-edge priority, when rst = 0 (highest first):
  - flush = 1: pc <= flush_addr; pc_valid <= 1; last_sel unchanged; `sel` and `stall` ignored; no error logged.
  - stall = 1: pc, last_sel and pc_valid hold; `sel` is not checked, so an illegal select during stall does not count.
  - sel >= NUM_SRC (illegal): pc holds, pc_valid unchanged, sel_err <= 1, err_cnt <= err_cnt + 1, saturating at 2^CNT_W - 1; last_sel unchanged.
  - Otherwise: pc <= (sel == SEQ_IDX) ? pc + INC : src_flat[sel*WIDTH +: WIDTH]; last_sel <= sel; pc_valid <= 1.
- Latency and arithmetic
  - One cycle: the value selected in cycle n appears on `pc` after edge n.
  - Addition is modulo 2^WIDTH with no carry out; pc = 32'hFFFF_FFFC with INC = 4 wraps to 0.
- Outputs and error logging
  - No high-impedance outputs anywhere; unused slots never drive Z.
  - sel_err and err_cnt clear only on rst.
- Legal parameter checks (elaboration)
  - NUM_SRC >= 2.
  - SEQ_IDX < NUM_SRC.
  - 2^SEL_W >= NUM_SRC.
  - CNT_W >= 1.
- Flush and stall asserted together: flush wins.

Test Plan:
- Reset, then sel = 2 for 3 cycles, no stall → pc = 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C; pc_valid goes 1 after the first edge; last_sel = 2.
- sel = 0 with slot0 = 0x0000_1000, then sel = 3 with slot3 = 0x0000_2000 → pc = 0x1000 then 0x2000 on consecutive edges; slot2 data = 0xDEAD_BEEF never appears.
- pc = 0x1000, stall = 1 for 2 cycles with sel = 0 and slot0 = 0x5000 → pc stays 0x1000. Stall released → pc = 0x5000 one cycle later.
- flush = 1, stall = 1, sel = 5, flush_addr = 0x0040_0004 → pc = 0x0040_0004; sel_err stays 0.
- NUM_SRC = 5 override: sel = 6 for 300 cycles with CNT_W = 8 → pc holds, sel_err = 1, err_cnt saturates at 255; assert rst for 1 cycle → pc = RESET_VAL, sel_err = 0, err_cnt = 0.
- pc = 0xFFFF_FFFC, sel = SEQ_IDX → pc = 0x0000_0000; pc_seq = 0x0000_0004.
